// File: rtl/vector_pkg.sv
// vector_pkg: types and constants shared by the vector arithmetic blocks.
//   fp16_t              - one IEEE-754 half-precision element
//   vaddsub_seq_state_t - sequencer FSM states
//   VADDSUB_LAT         - result latency of the FP16 add/sub unit, in cycles
`timescale 1ns/1ps
package vector_pkg;
    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } vaddsub_seq_state_t;

    localparam int VADDSUB_LAT = 2;
endpackage

// File: rtl/vaddsub_seq_if.sv
// vaddsub_seq_if: request/response bundle of the vector add/sub sequencer.
//   req_valid/req_ready  - request handshake, req_sub/req_a/req_b payload
//   resp_valid/resp_ready - response handshake, resp_out/resp_ovf_mask payload
//   Vectors are packed FP16, element i at [16i+:16].
//   master: the requester/consumer side; slave: the sequencer.
`timescale 1ns/1ps
interface vaddsub_seq_if #(
    parameter int NUM_ELEM = 8
);
    import vector_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_sub;
    logic [16*NUM_ELEM-1:0]  req_a;
    logic [16*NUM_ELEM-1:0]  req_b;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [16*NUM_ELEM-1:0]  resp_out;
    logic [NUM_ELEM-1:0]     resp_ovf_mask;

    modport master (
        output req_valid, req_sub, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_out, resp_ovf_mask
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_out, resp_ovf_mask
    );
endinterface

// File: rtl/vaddsub_seq.sv
// vaddsub_seq: serialises a NUM_ELEM-wide FP16 vector add/sub onto a single
// pipelined scalar FP16 add/sub unit and reassembles the results.
//   CLK, nRST        - clock (rising edge), asynchronous active-low reset
//   bus (slave)      - vector request/response handshake
//   au_enable, au_port_a, au_port_b, au_sub - operands to the scalar unit
//   au_out, au_overflow                     - scalar unit result, AU_LAT later
// One element is issued per cycle; an AU_LAT-deep {valid, idx} tag pipe that
// mirrors the unit's latency says which result slot each returning value owns.
`timescale 1ns/1ps
module vaddsub_seq
    import vector_pkg::*;
#(
    parameter int NUM_ELEM = 8,
    parameter int AU_LAT   = VADDSUB_LAT
) (
    input  logic              CLK,
    input  logic              nRST,
    vaddsub_seq_if.slave      bus,
    output logic              au_enable,
    output fp16_t             au_port_a,
    output fp16_t             au_port_b,
    output logic              au_sub,
    input  fp16_t             au_out,
    input  logic              au_overflow
);
    // One extra bit so a count of NUM_ELEM is representable, even at 32.
    localparam int IDXW = $clog2(NUM_ELEM) + 1;
    localparam int VW   = 16 * NUM_ELEM;

    vaddsub_seq_state_t state_reg, state_next;

    // Operands are latched into shift registers; element issue_idx is always
    // sitting in the low 16 bits while issuing.
    logic [VW-1:0]       a_sh_reg, b_sh_reg;
    logic                sub_reg;
    logic [IDXW-1:0]     issue_idx_reg;
    logic [IDXW-1:0]     cap_cnt_reg;
    logic [IDXW-1:0]     cap_cnt_next;

    logic                tag_valid_reg [AU_LAT];
    logic [IDXW-1:0]     tag_idx_reg   [AU_LAT];

    logic [VW-1:0]       result_reg, result_next;
    logic [NUM_ELEM-1:0] ovf_reg, ovf_next;

    logic                accept;
    logic                issuing;
    logic                capture;
    logic [IDXW-1:0]     tail_idx;

    assign accept       = (state_reg == IDLE) && bus.req_valid;
    assign issuing      = (state_reg == ISSUE);
    // Capture is driven purely by the tag pipe: a legitimate zero result
    // must still be written.
    assign capture      = tag_valid_reg[AU_LAT-1];
    assign tail_idx     = tag_idx_reg[AU_LAT-1];
    assign cap_cnt_next = cap_cnt_reg + IDXW'(capture);

    assign bus.req_ready     = (state_reg == IDLE);
    assign bus.resp_valid    = (state_reg == RESP);
    assign bus.resp_out      = result_reg;
    assign bus.resp_ovf_mask = ovf_reg;

    assign au_enable = issuing;
    assign au_port_a = issuing ? a_sh_reg[15:0] : '0;
    assign au_port_b = issuing ? b_sh_reg[15:0] : '0;
    assign au_sub    = issuing ? sub_reg : 1'b0;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (bus.req_valid) state_next = ISSUE;
            ISSUE: if (issue_idx_reg == IDXW'(NUM_ELEM - 1)) state_next = DRAIN;
            // Move on together with the final capture so resp_valid rises
            // the cycle the last result is visible in result_reg.
            DRAIN: if (cap_cnt_next == IDXW'(NUM_ELEM)) state_next = RESP;
            RESP:  if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sub_reg       <= 1'b0;
            issue_idx_reg <= '0;
            cap_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_sh_reg      <= bus.req_a;
                b_sh_reg      <= bus.req_b;
                sub_reg       <= bus.req_sub;
                issue_idx_reg <= '0;
                cap_cnt_reg   <= '0;
            end else begin
                if (issuing) begin
                    a_sh_reg      <= a_sh_reg >> 16;
                    b_sh_reg      <= b_sh_reg >> 16;
                    issue_idx_reg <= issue_idx_reg + 1'b1;
                end
                if (capture) begin
                    cap_cnt_reg <= cap_cnt_next;
                end
            end
        end
    end

    // In-flight tag pipe, same depth as the unit's latency.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < AU_LAT; i++) begin
                tag_valid_reg[i] <= 1'b0;
                tag_idx_reg[i]   <= '0;
            end
        end else begin
            tag_valid_reg[0] <= issuing;
            tag_idx_reg[0]   <= issue_idx_reg;
            for (int i = AU_LAT - 1; i > 0; i--) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_idx_reg[i]   <= tag_idx_reg[i-1];
            end
        end
    end

    // Per-element write decode for the result and overflow slots.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEM; gi++) begin : g_slot
            logic hit;
            assign hit = capture && (tail_idx == IDXW'(gi));
            assign result_next[16*gi +: 16] = hit ? au_out : result_reg[16*gi +: 16];
            assign ovf_next[gi]             = hit ? au_overflow : ovf_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            result_reg <= '0;
            ovf_reg    <= '0;
        end else if (accept) begin
            result_reg <= '0;
            ovf_reg    <= '0;
        end else begin
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
        end
    end
endmodule

// File: tb/tb_vaddsub_seq.sv
`timescale 1ns/1ps
module tb_vaddsub_seq;
    import vector_pkg::*;

    localparam int NE     = 8;
    localparam int TB_LAT = 2;
    localparam int BW     = 16 * NE;

    logic  CLK;
    logic  nRST;
    logic  au_enable;
    fp16_t au_port_a;
    fp16_t au_port_b;
    logic  au_sub;
    fp16_t au_out;
    logic  au_overflow;

    int total;
    int bad;

    vaddsub_seq_if #(.NUM_ELEM(NE)) bus ();

    vaddsub_seq #(.NUM_ELEM(NE), .AU_LAT(TB_LAT)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus),
        .au_enable   (au_enable),
        .au_port_a   (au_port_a),
        .au_port_b   (au_port_b),
        .au_sub      (au_sub),
        .au_out      (au_out),
        .au_overflow (au_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural FP16 add/sub for normal operands, truncating; returns {ovf, result}.
    function automatic logic [16:0] fp_addsub(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic sa, sb, ts;
        int ea, eb, ma, mb, mr, er, t;
        sa = a[15]; sb = b[15] ^ sub;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'({1'b1, a[9:0]}); mb = int'({1'b1, b[9:0]});
        if (eb > ea || (eb == ea && mb > ma)) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            ts = sa; sa = sb; sb = ts;
        end
        mb = mb >> (ea - eb);
        er = ea;
        if (sa == sb) begin
            mr = ma + mb;
            if (mr >= 2048) begin mr = mr >> 1; er = er + 1; end
        end else begin
            mr = ma - mb;
            if (mr == 0) return 17'h0;
            while (mr < 1024) begin mr = mr << 1; er = er - 1; end
        end
        if (er >= 31) return {1'b1, sa, 5'h1f, 10'h0};
        return {1'b0, sa, 5'(er), 10'(mr)};
    endfunction

    // Stand-in for the FP16 add/sub unit: TB_LAT-cycle pipe, zero when not valid.
    logic [16:0] au_pipe [TB_LAT];
    logic        au_pv   [TB_LAT];
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < TB_LAT; k++) begin au_pipe[k] <= '0; au_pv[k] <= 1'b0; end
        end else begin
            au_pipe[0] <= fp_addsub(au_port_a, au_port_b, au_sub);
            au_pv[0]   <= au_enable;
            for (int k = 1; k < TB_LAT; k++) begin au_pipe[k] <= au_pipe[k-1]; au_pv[k] <= au_pv[k-1]; end
        end
    end
    assign au_out      = au_pv[TB_LAT-1] ? au_pipe[TB_LAT-1][15:0] : 16'h0;
    assign au_overflow = au_pv[TB_LAT-1] ? au_pipe[TB_LAT-1][16] : 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub);
        bus.req_a = a; bus.req_b = b; bus.req_sub = sub; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Advances until resp_valid; lat is the cycle number (acceptance = 0), -1 on timeout.
    task automatic wait_resp(input int start, output int lat);
        lat = start;
        while (!bus.resp_valid && lat < 200) begin tick(); lat++; end
        if (!bus.resp_valid) lat = -1;
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #3;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b want=1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b want=0", bus.resp_valid); end
        total++; if (au_enable !== 1'b0) begin bad++; $display("FAIL reset_au_enable got=%0b want=0", au_enable); end
        total++; if ({au_port_a, au_port_b, au_sub} !== 33'h0) begin bad++; $display("FAIL reset_au_ports got=%h want=0", {au_port_a, au_port_b, au_sub}); end
        total++; if (bus.resp_out !== '0) begin bad++; $display("FAIL reset_resp_out got=%h want=0", bus.resp_out); end
        total++; if (bus.resp_ovf_mask !== '0) begin bad++; $display("FAIL reset_mask got=%h want=0", bus.resp_ovf_mask); end
        tick(); tick();
        nRST = 1'b1;
        tick();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b want=1", bus.req_ready); end
        $display("reset: done");
    endtask

    task automatic test_add();
        int lat;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%0b want=1", bus.req_ready); end
        start_op({NE{16'h3C00}}, {NE{16'h4000}}, 1'b0);
        wait_resp(1, lat);
        $display("op add lat=%0d out=%h mask=%h", lat, bus.resp_out, bus.resp_ovf_mask);
        total++; if (lat !== 11) begin bad++; $display("FAIL add_latency got=%0d want=11", lat); end
        total++; if (bus.resp_out !== {NE{16'h4200}}) begin bad++; $display("FAIL add_out got=%h want=%h", bus.resp_out, {NE{16'h4200}}); end
        total++; if (bus.resp_ovf_mask !== 8'h00) begin bad++; $display("FAIL add_mask got=%h want=00", bus.resp_ovf_mask); end
        finish_resp();
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL add_resp_drop got=%0b want=0", bus.resp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL add_back_idle got=%0b want=1", bus.req_ready); end
    endtask

    task automatic test_order();
        int lat;
        logic [BW-1:0] exp_out;
        exp_out = {16'h4800, 16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h4880};
        start_op({NE{16'h3C00}},
                 {16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00, 16'h4800}, 1'b0);
        total++; if (au_enable !== 1'b1) begin bad++; $display("FAIL order_en_c1 got=%0b want=1", au_enable); end
        total++; if (au_port_a !== 16'h3C00) begin bad++; $display("FAIL order_a_c1 got=%h want=3c00", au_port_a); end
        total++; if (au_port_b !== 16'h4800) begin bad++; $display("FAIL order_b_c1 got=%h want=4800", au_port_b); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL order_busy got=%0b want=0", bus.req_ready); end
        tick();
        total++; if (au_port_b !== 16'h3C00) begin bad++; $display("FAIL order_b_c2 got=%h want=3c00", au_port_b); end
        repeat (7) tick();
        total++; if ({au_enable, au_port_a, au_port_b} !== 33'h0) begin bad++; $display("FAIL order_drain_ports got=%h want=0", {au_enable, au_port_a, au_port_b}); end
        wait_resp(9, lat);
        $display("op order lat=%0d out=%h mask=%h", lat, bus.resp_out, bus.resp_ovf_mask);
        total++; if (lat !== 11) begin bad++; $display("FAIL order_latency got=%0d want=11", lat); end
        total++; if (bus.resp_out !== exp_out) begin bad++; $display("FAIL order_out got=%h want=%h", bus.resp_out, exp_out); end
        finish_resp();
    endtask

    task automatic test_sub();
        int lat;
        start_op({NE{16'h4200}}, {NE{16'h3C00}}, 1'b1);
        total++; if (au_sub !== 1'b1) begin bad++; $display("FAIL sub_au_sub got=%0b want=1", au_sub); end
        wait_resp(1, lat);
        $display("op sub lat=%0d out=%h mask=%h", lat, bus.resp_out, bus.resp_ovf_mask);
        total++; if (bus.resp_out !== {NE{16'h4000}}) begin bad++; $display("FAIL sub_out got=%h want=%h", bus.resp_out, {NE{16'h4000}}); end
        finish_resp();
        start_op({NE{16'h4500}}, {NE{16'h4500}}, 1'b1);
        wait_resp(1, lat);
        $display("op sub_zero lat=%0d out=%h mask=%h", lat, bus.resp_out, bus.resp_ovf_mask);
        total++; if (lat !== 11) begin bad++; $display("FAIL sub_zero_latency got=%0d want=11", lat); end
        total++; if (bus.resp_out !== {BW{1'b0}}) begin bad++; $display("FAIL sub_zero_out got=%h want=0", bus.resp_out); end
        finish_resp();
    endtask

    task automatic test_ovf();
        int lat;
        logic [BW-1:0] a_v;
        logic [BW-1:0] exp_out;
        a_v = {NE{16'h3C00}};
        a_v[48 +: 16] = 16'h7BFF;
        exp_out = {16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h7C00, 16'h4000, 16'h4000, 16'h4000};
        start_op(a_v, a_v, 1'b0);
        wait_resp(1, lat);
        $display("op ovf lat=%0d out=%h mask=%h", lat, bus.resp_out, bus.resp_ovf_mask);
        total++; if (bus.resp_out !== exp_out) begin bad++; $display("FAIL ovf_out got=%h want=%h", bus.resp_out, exp_out); end
        total++; if (bus.resp_ovf_mask !== 8'h08) begin bad++; $display("FAIL ovf_mask got=%h want=08", bus.resp_ovf_mask); end
        finish_resp();
    endtask

    task automatic test_stall();
        int lat;
        int held;
        start_op({NE{16'h3C00}}, {NE{16'h4000}}, 1'b0);
        // A competing request while busy must be ignored.
        bus.req_b = {NE{16'h4400}};
        bus.req_valid = 1'b1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL stall_busy_ready got=%0b want=0", bus.req_ready); end
        tick(); tick();
        bus.req_valid = 1'b0;
        // resp_ready while nothing is pending has no effect.
        bus.resp_ready = 1'b1;
        tick(); tick();
        bus.resp_ready = 1'b0;
        total++; if ({bus.resp_valid, bus.req_ready} !== 2'b00) begin bad++; $display("FAIL stall_early_ready got=%b want=00", {bus.resp_valid, bus.req_ready}); end
        wait_resp(5, lat);
        total++; if (lat !== 11) begin bad++; $display("FAIL stall_latency got=%0d want=11", lat); end
        held = 0;
        repeat (20) begin
            if (bus.resp_valid === 1'b1 && bus.resp_out === {NE{16'h4200}}) held++;
            tick();
        end
        $display("op stall lat=%0d held=%0d out=%h", lat, held, bus.resp_out);
        total++; if (held !== 20) begin bad++; $display("FAIL stall_hold got=%0d want=20", held); end
        finish_resp();
        tick(); tick();
        total++; if ({bus.req_ready, au_enable} !== 2'b10) begin bad++; $display("FAIL stall_no_ghost got=%b want=10", {bus.req_ready, au_enable}); end
        start_op({NE{16'h3C00}}, {NE{16'h4400}}, 1'b0);
        wait_resp(1, lat);
        $display("op stall_second lat=%0d out=%h", lat, bus.resp_out);
        total++; if (bus.resp_out !== {NE{16'h4500}}) begin bad++; $display("FAIL stall_second_out got=%h want=%h", bus.resp_out, {NE{16'h4500}}); end
        finish_resp();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        start_op({NE{16'h3C00}}, {NE{16'h4000}}, 1'b0);
        repeat (4) tick();
        nRST = 1'b0;
        #1;
        total++; if ({bus.req_ready, bus.resp_valid, au_enable} !== 3'b100) begin bad++; $display("FAIL midrst_ctrl got=%b want=100", {bus.req_ready, bus.resp_valid, au_enable}); end
        total++; if ({au_port_a, au_port_b} !== 32'h0) begin bad++; $display("FAIL midrst_ports got=%h want=0", {au_port_a, au_port_b}); end
        total++; if (bus.resp_out !== {BW{1'b0}}) begin bad++; $display("FAIL midrst_out got=%h want=0", bus.resp_out); end
        tick(); tick();
        nRST = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) seen++;
        end
        $display("op reset_mid stray=%0d", seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_stray got=%0d want=0", seen); end
        start_op({NE{16'h4200}}, {NE{16'h3C00}}, 1'b1);
        wait_resp(1, lat);
        $display("op reset_mid_fresh lat=%0d out=%h", lat, bus.resp_out);
        total++; if (lat !== 11) begin bad++; $display("FAIL midrst_fresh_latency got=%0d want=11", lat); end
        total++; if (bus.resp_out !== {NE{16'h4000}}) begin bad++; $display("FAIL midrst_fresh_out got=%h want=%h", bus.resp_out, {NE{16'h4000}}); end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        int c;
        int first;
        int second;
        logic [BW-1:0] out2;
        c = 0; first = -1; second = -1; out2 = '0;
        bus.req_a = {NE{16'h3C00}}; bus.req_b = {NE{16'h3C00}}; bus.req_sub = 1'b0;
        bus.req_valid = 1'b1;
        bus.resp_ready = 1'b1;
        while (c < 60 && second < 0) begin
            if (bus.resp_valid === 1'b1) begin
                if (first < 0) first = c;
                else begin second = c; out2 = bus.resp_out; end
            end
            tick();
            c++;
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        $display("op back_to_back first=%0d second=%0d out=%h", first, second, out2);
        total++; if (first !== 11) begin bad++; $display("FAIL b2b_first got=%0d want=11", first); end
        total++; if (second !== 23) begin bad++; $display("FAIL b2b_second got=%0d want=23", second); end
        total++; if (out2 !== {NE{16'h4000}}) begin bad++; $display("FAIL b2b_out got=%h want=%h", out2, {NE{16'h4000}}); end
        tick();
        total++; if ({bus.req_ready, au_enable} !== 2'b10) begin bad++; $display("FAIL b2b_idle got=%b want=10", {bus.req_ready, au_enable}); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        nRST = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_sub = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_add();
        test_order();
        test_sub();
        test_ovf();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vaddsub_seq.md
VADDSUB_SEQ -- requirements
Module: vaddsub_seq

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 8, meaning FP16 elements per vector op (legal values 1..32).
REQ-002 SHALL have parameter AU_LAT, default 2, meaning cycles from adder enable sample to adder result valid.
REQ-003 SHALL have port CLK  in  1  clock, rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  vector op request.
REQ-006 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_sub  in  1  1 = subtract (a-b), 0 = add.
REQ-008 SHALL have ports req_a, req_b  in  16*NUM_ELEM  packed FP16 operand vectors, element i at [16i+:16].
REQ-009 SHALL have port resp_valid  out  1  result vector available.
REQ-010 SHALL have port resp_ready  in  1  consumer takes result.
REQ-011 SHALL have port resp_out  out  16*NUM_ELEM  packed FP16 results, same element order.
REQ-012 SHALL have port resp_ovf_mask  out  NUM_ELEM  per-element overflow flags.
REQ-013 SHALL have ports au_enable out 1, au_port_a out 16, au_port_b out 16, au_sub out 1: drive to the FP16 add/sub unit.
REQ-014 SHALL have ports au_out in 16, au_overflow in 1: returned from the add/sub unit (forced zero by the unit when not valid).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN, RESP.
REQ-016 IDLE: req_ready=1; on req_valid latch req_a, req_b, req_sub, clear issue/capture counters and resp_ovf_mask, go ISSUE.
REQ-017 ISSUE: au_enable=1, au_port_a/au_port_b = latched element issue_idx, au_sub = latched req_sub; issue_idx increments each cycle; after element NUM_ELEM-1 go DRAIN.
REQ-018 Outside ISSUE au_enable SHALL be 0 and au_port_a/au_port_b/au_sub SHALL be 0.
REQ-019 SHALL track in-flight elements with an AU_LAT-deep shift register of {valid, idx}; entry exiting the tail writes au_out to result[idx] and au_overflow to resp_ovf_mask[idx].
REQ-020 Capture SHALL rely only on the internal tag pipe, never on au_out being nonzero.
REQ-021 DRAIN: leave for RESP on the cycle after the capture count reaches NUM_ELEM.
REQ-022 RESP: resp_valid=1, resp_out/resp_ovf_mask held stable; on resp_ready go IDLE.
REQ-023 Latency: acceptance in cycle 0 -> element i issued in cycle 1+i -> resp_valid first high in cycle NUM_ELEM+AU_LAT+1 (11 with defaults).
REQ-024 req_ready SHALL be 0 in ISSUE, DRAIN, RESP; req_valid there SHALL be ignored, no latch change.
REQ-025 resp_ready while resp_valid=0 SHALL have no effect; resp_valid held indefinitely until resp_ready.
REQ-026 Throughput: one vector op per NUM_ELEM+AU_LAT+2 cycles minimum (RESP handshake, then IDLE accept).
REQ-027 issue_idx and idx tags SHALL be $clog2(NUM_ELEM)+1 bits wide to avoid wrap at NUM_ELEM=32.

Reset
REQ-028 On nRST low: state=IDLE, req_ready=1, resp_valid=0, au_enable=0, au ports 0, resp_out=0, resp_ovf_mask=0, counters and tag pipe cleared.
REQ-029 Reset mid-operation SHALL discard the op and all in-flight tags; no partial resp_valid after release.

Structure
REQ-030 State enum vaddsub_seq_state_t and constant VADDSUB_LAT=2 SHALL live in vector_pkg; FP16 element type from vector_pkg.
REQ-031 No sub-module; the parent instantiates the add/sub unit and wires au_* ports with the same CLK/nRST.

Verification
REQ-032 Add, NUM_ELEM=8, all a=0x3C00, b=0x4000 -> resp_out all 0x4200, mask 0, resp_valid in cycle 11.
REQ-033 Sub, a[i]=0x4200, b[i]=0x3C00 -> all 0x4000; a=b=0x4500 sub -> 0x0000.
REQ-034 Element 3 a=b=0x7BFF add, rest 0x3C00+0x3C00 -> out[3]=0x7C00, mask=0x08, others 0x4000.
REQ-035 resp_ready low 20 cycles then high; req_valid pulsed during ISSUE -> result stable, second request accepted only after return to IDLE.
REQ-036 nRST asserted in cycle 5 of an op -> all outputs reset values, no resp_valid; fresh op after release returns correct results.
